// File: rtl/wb_lsu_initiator.sv
// Wishbone B4 classic load/store initiator for the core's data bus.
// One request at a time: decode, single bus cycle, one-cycle response strobe.
// Optional bus timeout enabled by defining WB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request; decodes funct3 and alignment on req_valid
// BUS   | Wishbone cycle in flight; outputs held until ack/err (or timeout)
// RESP  | rsp_valid high for one cycle, then back to IDLE
module wb_lsu_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_misalign,
  output logic [31:0] dwb_adr_o,
  output logic [31:0] dwb_dat_o,
  input  logic [31:0] dwb_dat_i,
  output logic        dwb_we_o,
  output logic [3:0]  dwb_sel_o,
  output logic        dwb_cyc_o,
  output logic        dwb_stb_o,
  input  logic        dwb_ack_i,
  input  logic        dwb_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        we_q, we_d, cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d, rsp_mis_q, rsp_mis_d;

  logic        req_legal, req_misal;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

`ifdef WB_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            to_expired;
  assign to_expired = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_to_cfg = TIMEOUT_CYCLES + TO_W;
`endif

  // Request decode: legality, alignment, byte lanes and replicated store data.
  always_comb begin
    if (req_we) req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    req_misal = 1'b0;
    req_sel   = 4'b1111;
    req_dat   = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_sel = 4'b0001 << req_addr[1:0];
        req_dat = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_misal = req_addr[0];
        req_sel   = 4'b0011 << {req_addr[1], 1'b0};
        req_dat   = {2{req_wdata[15:0]}};
      end
      default: req_misal = |req_addr[1:0];
    endcase
    if (!req_we) req_dat = 32'd0;
  end

  // Lane selection and sign/zero extension of the returned read data.
  always_comb begin
    ld_byte = dwb_dat_i[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? dwb_dat_i[31:16] : dwb_dat_i[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dwb_dat_i;
    endcase
  end

  // Next-state and next-output logic; rsp_* default to 0 so they only live in RESP.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    cyc_d       = cyc_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    rsp_mis_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
    to_d        = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_legal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else if (req_misal) begin
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
            state_d     = ST_RESP;
          end else begin
            adr_d   = {req_addr[31:2], 2'b00};
            dat_d   = req_dat;
            we_d    = req_we;
            sel_d   = req_sel;
            cyc_d   = 1'b1;
            f3_d    = req_funct3;
            off_d   = req_addr[1:0];
            state_d = ST_BUS;
`ifdef WB_TIMEOUT_EN
            to_d    = '0;
`endif
          end
        end
      end
      ST_BUS: begin
        if (dwb_ack_i || dwb_err_i) begin
          adr_d       = 32'd0;
          dat_d       = 32'd0;
          we_d        = 1'b0;
          sel_d       = 4'd0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = dwb_err_i;
          rsp_rdata_d = (dwb_err_i || we_q) ? 32'd0 : ld_data;
          state_d     = ST_RESP;
`ifdef WB_TIMEOUT_EN
        end else if (to_expired) begin
          adr_d       = 32'd0;
          dat_d       = 32'd0;
          we_d        = 1'b0;
          sel_d       = 4'd0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          to_d = to_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      cyc_q       <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      cyc_q       <= cyc_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mis_q   <= rsp_mis_d;
`ifdef WB_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_misalign = rsp_mis_q;
  assign dwb_adr_o    = adr_q;
  assign dwb_dat_o    = dat_q;
  assign dwb_we_o     = we_q;
  assign dwb_sel_o    = sel_q;
  assign dwb_cyc_o    = cyc_q;
  assign dwb_stb_o    = cyc_q;

endmodule
